// File: rtl/cmd_seq_rx_if.sv
// Host register/memory bus for the serial command capture block.
interface cmd_seq_rx_if;
  logic [15:0] BUS_ADD;
  logic [7:0]  BUS_DATA_IN;
  logic        BUS_WR;
  logic        BUS_RD;
  logic [7:0]  BUS_DATA_OUT;

  modport master (
    output BUS_ADD, BUS_DATA_IN, BUS_WR, BUS_RD,
    input  BUS_DATA_OUT
  );

  modport slave (
    input  BUS_ADD, BUS_DATA_IN, BUS_WR, BUS_RD,
    output BUS_DATA_OUT
  );
endinterface

// File: rtl/cmd_seq_rx.sv
// Serial command frame receiver: samples an async CMD_CLK/CMD_DATA pair,
// packs bits MSB-first into a capture memory and ends a frame after an idle run.
module cmd_seq_rx #(
  parameter int unsigned MEM_SIZE = 2048
) (
  input  logic         BUS_CLK,
  input  logic         RST,
  cmd_seq_rx_if.slave  bus,
  input  logic         CMD_CLK,
  input  logic         CMD_DATA,
  output logic         RX_DONE
);

  localparam int unsigned AW = $clog2(MEM_SIZE);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t        state;
  logic          soft_rst;
  logic          rst_int;
  logic          enable;
  logic          sample_rise;
  logic [7:0]    idle_bits;
  logic          done;
  logic          overflow;
  logic [15:0]   bit_count;
  logic [15:0]   pos;
  logic [7:0]    zero_run;
  logic [PW-1:0] ptr;
  logic [7:0]    shreg;
  logic [2:0]    nbits;

  logic [2:0]    cclk_sync;
  logic [1:0]    cdat_sync;
  logic          sample;
  logic          bit_in;

  logic [7:0]    mem [MEM_SIZE];
  logic [AW-1:0] mem_idx;
  logic          is_mem;
  logic          arm_wr;
  logic          host_mem_we;

  logic [7:0]    sh_next;
  logic [3:0]    nb_next;
  logic [7:0]    zr_next;
  logic [7:0]    eff_idle;
  logic [15:0]   pos_inc;
  logic          take;
  logic          byte_full;
  logic          frame_end;
  logic          ptr_full;
  logic          cap_we;
  logic [7:0]    cap_data;
  logic          unused_rd;

  assign unused_rd = bus.BUS_RD;
  assign rst_int   = RST | soft_rst;
  assign RX_DONE   = done;

  always_ff @(posedge BUS_CLK) begin
    if (RST) soft_rst <= 1'b0;
    else     soft_rst <= bus.BUS_WR && (bus.BUS_ADD == 16'd0);
  end

  // Left unreset on purpose: clearing them could fake a CMD_CLK edge.
  always_ff @(posedge BUS_CLK) begin
    cclk_sync <= {cclk_sync[1:0], CMD_CLK};
    cdat_sync <= {cdat_sync[0], CMD_DATA};
  end

  assign sample = sample_rise ? (cclk_sync[1] & ~cclk_sync[2])
                              : (~cclk_sync[1] & cclk_sync[2]);
  assign bit_in = cdat_sync[1];

  assign is_mem      = (bus.BUS_ADD >= 16'd8) && (bus.BUS_ADD < 16'(MEM_SIZE + 8));
  assign mem_idx     = AW'(bus.BUS_ADD - 16'd8);
  assign arm_wr      = bus.BUS_WR && (bus.BUS_ADD == 16'd1) && enable;
  assign host_mem_we = bus.BUS_WR && is_mem && (state != S_CAPTURE) && !rst_int;

  always_comb begin
    sh_next   = {shreg[6:0], bit_in};
    nb_next   = {1'b0, nbits} + 4'd1;
    zr_next   = bit_in ? '0 : zero_run + 8'd1;
    eff_idle  = (idle_bits == '0) ? 8'd1 : idle_bits;
    pos_inc   = (pos == '1) ? pos : pos + 16'd1;
    take      = sample && enable && !arm_wr && (state == S_CAPTURE);
    byte_full = (nb_next == 4'd8);
    frame_end = !bit_in && (zr_next >= eff_idle);
    ptr_full  = (ptr == PW'(MEM_SIZE));
    cap_we    = take && !rst_int && !ptr_full && (byte_full || frame_end);
    // A full byte shifts by zero; a partial one is left-aligned with zero fill.
    cap_data  = sh_next << (4'd8 - nb_next);
  end

  always_ff @(posedge BUS_CLK) begin
    if (cap_we)           mem[ptr[AW-1:0]] <= cap_data;
    else if (host_mem_we) mem[mem_idx]     <= bus.BUS_DATA_IN;
  end

  always_ff @(posedge BUS_CLK) begin
    if (rst_int) begin
      bus.BUS_DATA_OUT <= '0;
    end else if (is_mem) begin
      bus.BUS_DATA_OUT <= mem[mem_idx];
    end else begin
      case (bus.BUS_ADD)
        16'd1:   bus.BUS_DATA_OUT <= {6'b0, overflow, done};
        16'd2:   bus.BUS_DATA_OUT <= {6'b0, sample_rise, enable};
        16'd3:   bus.BUS_DATA_OUT <= bit_count[7:0];
        16'd4:   bus.BUS_DATA_OUT <= bit_count[15:8];
        16'd5:   bus.BUS_DATA_OUT <= idle_bits;
        default: bus.BUS_DATA_OUT <= '0;
      endcase
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (rst_int) begin
      state       <= S_IDLE;
      done        <= 1'b0;
      overflow    <= 1'b0;
      bit_count   <= '0;
      enable      <= 1'b0;
      sample_rise <= 1'b0;
      idle_bits   <= 8'd8;
      ptr         <= '0;
      shreg       <= '0;
      nbits       <= '0;
      zero_run    <= '0;
      pos         <= '0;
    end else begin
      if (bus.BUS_WR && bus.BUS_ADD == 16'd2) {sample_rise, enable} <= bus.BUS_DATA_IN[1:0];
      if (bus.BUS_WR && bus.BUS_ADD == 16'd5) idle_bits <= bus.BUS_DATA_IN;

      if (arm_wr) begin
        state     <= S_ARMED;
        done      <= 1'b0;
        overflow  <= 1'b0;
        bit_count <= '0;
        zero_run  <= '0;
        ptr       <= '0;
        shreg     <= '0;
        nbits     <= '0;
        pos       <= '0;
      end else if (!enable) begin
        state <= S_IDLE;
      end else if (sample) begin
        case (state)
          S_ARMED: begin
            if (bit_in) begin
              state     <= S_CAPTURE;
              shreg     <= 8'h01;
              nbits     <= 3'd1;
              pos       <= 16'd1;
              bit_count <= 16'd1;
              zero_run  <= '0;
            end
          end
          S_CAPTURE: begin
            shreg    <= sh_next;
            nbits    <= nb_next[2:0];
            pos      <= pos_inc;
            zero_run <= zr_next;
            if (bit_in) bit_count <= pos_inc;
            if (byte_full && !ptr_full) begin
              ptr <= ptr + PW'(1);
              if (ptr == PW'(MEM_SIZE - 1)) overflow <= 1'b1;
            end
            if (frame_end) begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
